bm_if_reset_sink: RTL and testbench

//  Downstream stage for the reset-gated AND micro benchmark (2-bit data word + 1-bit flag per cycle).

---
 rtl/bm_if_reset_sink.sv | 78 +++++++
 tb/tb_bm_if_reset_sink.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bm_if_reset_sink.sv
// rtl/bm_if_reset_sink.sv - FWFT sink FIFO for the reset-gated AND benchmark with flag counter and sticky overflow
module bm_if_reset_sink #(
    parameter int BITS  = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BITS-1:0]            data_in,
    input  logic                       flag_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BITS-1:0]            data_out,
    output logic                       flag_out,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           flag_count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [BITS:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [BITS:0]   head;
    logic            full;
    logic            push;
    logic            pop;

    assign full      = (level == LW'(DEPTH));
    assign in_ready  = !full;
    assign out_valid = (level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head is read straight from registered storage; masked while empty so stale entries never leak out.
    assign head      = mem[rd_ptr];
    assign data_out  = out_valid ? head[BITS-1:0] : '0;
    assign flag_out  = out_valid ? head[BITS] : 1'b0;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {flag_in, data_in};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            flag_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (push && flag_in && (flag_count != '1)) begin
                flag_count <= flag_count + CNT_W'(1);
            end
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bm_if_reset_sink.sv
// tb/tb_bm_if_reset_sink.sv - randomized and directed bench for bm_if_reset_sink against a queue model
module tb_bm_if_reset_sink;

    localparam int BITS  = 2;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [BITS-1:0]  data_in;
    logic             flag_in;
    logic             out_valid;
    logic             out_ready;
    logic [BITS-1:0]  data_out;
    logic             flag_out;
    logic [2:0]       level;
    logic [CNT_W-1:0] flag_count;
    logic             overflow;

    int vectors     = 0;
    int miscompares = 0;

    logic [BITS:0] mq[$];
    int            m_cnt;
    bit            m_ovf;

    always #5 clock = ~clock;

    bm_if_reset_sink #(.BITS(BITS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .flag_in    (flag_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .flag_out   (flag_out),
        .level      (level),
        .flag_count (flag_count),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [BITS:0] h;
        int            n;
        n = mq.size();
        h = (n > 0) ? mq[0] : '0;
        check({tag, "_out_valid"},  32'(out_valid),  32'(n > 0));
        check({tag, "_in_ready"},   32'(in_ready),   32'(n < DEPTH));
        check({tag, "_data_out"},   32'(data_out),   32'(h[BITS-1:0]));
        check({tag, "_flag_out"},   32'(flag_out),   32'(h[BITS]));
        check({tag, "_level"},      32'(level),      32'(n));
        check({tag, "_flag_count"}, 32'(flag_count), 32'(m_cnt));
        check({tag, "_overflow"},   32'(overflow),   32'(m_ovf));
    endtask

    // Called #1 after a rising edge; applies inputs, clocks once, advances the model, checks.
    task automatic step(input string tag, input logic iv, input logic [BITS-1:0] d,
                        input logic f, input logic ordy);
        bit do_push, do_pop, do_ovf;
        in_valid  = iv;
        data_in   = d;
        flag_in   = f;
        out_ready = ordy;
        do_push = iv && (mq.size() < DEPTH);
        do_pop  = ordy && (mq.size() > 0);
        do_ovf  = iv && (mq.size() == DEPTH);
        @(posedge clock);
        #1;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back({f, d});
            if (f && m_cnt < CMAX) m_cnt++;
        end
        if (do_ovf) m_ovf = 1'b1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        #1;
        mq.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        check_all({tag, "_async"});
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_all({tag, "_rel"});
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        flag_in   = 1'b0;
        m_cnt     = 0;
        m_ovf     = 1'b0;

        do_reset("rst");

        step("single", 1'b1, 2'b10, 1'b1, 1'b0);
        check("single_data", 32'(data_out), 32'h2);
        check("single_flag", 32'(flag_out), 32'h1);
        step("single_pop", 1'b0, 2'b00, 1'b0, 1'b1);

        step("fill0", 1'b1, 2'd0, 1'b0, 1'b0);
        step("fill1", 1'b1, 2'd1, 1'b0, 1'b0);
        step("fill2", 1'b1, 2'd2, 1'b0, 1'b0);
        step("fill3", 1'b1, 2'd3, 1'b0, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'h0);
        step("fill4", 1'b1, 2'd1, 1'b1, 1'b0);
        check("ovf_level", 32'(level), 32'h4);
        check("ovf_sticky", 32'(overflow), 32'h1);
        // Pop in the full cycle while offering: the offered word must still be dropped.
        step("full_pop_push", 1'b1, 2'd2, 1'b1, 1'b1);
        check("full_pop_level", 32'(level), 32'h3);
        for (int i = 0; i < 4; i++) step("drain", 1'b0, 2'd0, 1'b0, 1'b1);

        do_reset("rst2");
        for (int i = 0; i < 10; i++) begin
            step("stream", 1'b1, 2'(i % 4), 1'b0, 1'b1);
            check("stream_level", 32'(level), 32'h1);
            check("stream_data", 32'(data_out), 32'(i % 4));
        end

        for (int i = 0; i < 20; i++) step("sat", 1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b1);
        check("sat_count", 32'(flag_count), 32'(CMAX));
        step("sat_hold", 1'b1, 2'd1, 1'b1, 1'b1);

        do_reset("rst3");
        for (int i = 0; i < 3; i++) step("mid_fill", 1'b1, 2'(i), 1'b1, 1'b0);
        check("mid_level", 32'(level), 32'h3);
        do_reset("mid_rst");
        step("mid_after", 1'b1, 2'd3, 1'b0, 1'b0);
        check("mid_head", 32'(data_out), 32'h3);
        check("mid_alone", 32'(level), 32'h1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step("rnd", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
